// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory subsystem (state encoding,
// MMIO address, R.W encoding, RAM range decode).
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [15:0] MMIO_LED_ADDR = 16'hFE00;
  localparam logic        RW_READ       = 1'b0;
  localparam logic        RW_WRITE      = 1'b1;

  // An address belongs to RAM only when every bit above the RAM index is zero.
  function automatic logic in_ram(input logic [15:0] addr, input int unsigned depth_log2);
    return (depth_log2 >= 16) || ((addr >> depth_log2) == 16'd0);
  endfunction

endpackage

// File: rtl/lc3_mem_ram.sv
// Word-addressed single-port RAM: synchronous write, registered read.
// Contents are deliberately not reset.
module lc3_mem_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [0:(1<<AW)-1];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory subsystem: MAR/MDR, on-chip RAM and the Ready sequencer.
// Optional LED register at xFE00 is enabled by defining LC3_MEM_MMIO_EN.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ld_mar,
  input  logic        i_ld_mdr,
  input  logic        i_mio_en,
  input  logic        i_rw,
  input  logic [15:0] i_bus,
  output logic [15:0] o_mdr,
  output logic [15:0] o_mar,
  output logic        o_ready,
  output logic        o_busy
`ifdef LC3_MEM_MMIO_EN
  ,
  output logic [3:0]  o_led
`endif
);

  mem_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        ready_q, busy_q;
  logic        access;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [15:0] mem_rdata;
  logic        addr_in_ram;
`ifdef LC3_MEM_MMIO_EN
  logic [3:0]  led_q, led_d;
  logic        addr_is_led;
`endif

  // RAM is addressed with next-cycle MAR so a MAR load on the request edge
  // already produces read data for the new address before DONE.
  lc3_mem_ram #(
    .AW(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (mar_d[DEPTH_LOG2-1:0]),
    .wdata_i (mdr_q),
    .rdata_o (ram_rdata)
  );

  assign addr_in_ram = in_ram(mar_q, DEPTH_LOG2);
`ifdef LC3_MEM_MMIO_EN
  assign addr_is_led = (mar_q == MMIO_LED_ADDR);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    mar_d   = mar_q;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_ld_mar) begin
          mar_d = i_bus;
        end
        // WAIT_CYCLES=0 still spends one cycle in WAIT with a zero count,
        // keeping Ready at cycle WAIT_CYCLES+1 for every setting.
        if (i_mio_en) begin
          rw_d    = i_rw;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!i_mio_en) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!i_mio_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rdata = '0;
`ifdef LC3_MEM_MMIO_EN
    if (addr_is_led) begin
      mem_rdata = {12'h000, led_q};
    end else
`endif
    if (addr_in_ram) begin
      mem_rdata = ram_rdata;
    end
  end

  assign ram_we = access && (rw_q == RW_WRITE) && addr_in_ram;

  always_comb begin
    mdr_d = mdr_q;
    if (i_ld_mdr && !i_mio_en) begin
      mdr_d = i_bus;
    end else if (i_ld_mdr && access && (rw_q == RW_READ)) begin
      mdr_d = mem_rdata;
    end
  end

`ifdef LC3_MEM_MMIO_EN
  always_comb begin
    led_d = led_q;
    if (access && (rw_q == RW_WRITE) && addr_is_led) begin
      led_d = mdr_q[3:0];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_READ;
      mar_q   <= '0;
      mdr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LC3_MEM_MMIO_EN
      led_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      ready_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
`ifdef LC3_MEM_MMIO_EN
      led_q   <= led_d;
`endif
    end
  end

  assign o_mdr   = mdr_q;
  assign o_mar   = mar_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
`ifdef LC3_MEM_MMIO_EN
  assign o_led   = led_q;
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: one instance with WAIT_CYCLES=2 and one with
// WAIT_CYCLES=0, sharing bus/control lines but with separate MIO_EN.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_mar, ld_mdr, mio_en, mio_en0, rw;
  logic [15:0] bus;
  logic [15:0] mdr, mar, mdr0, mar0;
  logic        ready, busy, ready0, busy0;
`ifdef LC3_MEM_MMIO_EN
  logic [3:0]  led, led0;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_ld_mar(ld_mar), .i_ld_mdr(ld_mdr),
    .i_mio_en(mio_en), .i_rw(rw), .i_bus(bus), .o_mdr(mdr), .o_mar(mar),
    .o_ready(ready), .o_busy(busy)
`ifdef LC3_MEM_MMIO_EN
    , .o_led(led)
`endif
  );

  lc3_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_ld_mar(ld_mar), .i_ld_mdr(ld_mdr),
    .i_mio_en(mio_en0), .i_rw(rw), .i_bus(bus), .o_mdr(mdr0), .o_mar(mar0),
    .o_ready(ready0), .o_busy(busy0)
`ifdef LC3_MEM_MMIO_EN
    , .o_led(led0)
`endif
  );

  task automatic load_mar(input logic [15:0] v);
    @(negedge clk); bus = v; ld_mar = 1'b1;
    @(negedge clk); ld_mar = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    @(negedge clk); bus = v; ld_mdr = 1'b1;
    @(negedge clk); ld_mdr = 1'b0;
  endtask

  // Runs one access; lat is the edge index (0 = request edge) where Ready was
  // first seen, -1 if it never came. data is MDR in that same cycle.
  task automatic access(input bit sel, input logic w, input logic ldm, input bit flip_rw,
                        output int lat, output logic [15:0] data);
    @(negedge clk); rw = w; ld_mdr = ldm;
    if (sel) mio_en0 = 1'b1; else mio_en = 1'b1;
    lat = -1; data = 'x;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 0 && flip_rw) rw = ~w;
      if (sel ? ready0 : ready) begin
        lat = k; data = sel ? mdr0 : mdr;
        break;
      end
    end
    @(negedge clk); mio_en = 1'b0; mio_en0 = 1'b0; ld_mdr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (mar !== 16'h0) begin errors++; $display("FAIL reset_mar got %h want 0000", mar); end
    checks++; if (mdr !== 16'h0) begin errors++; $display("FAIL reset_mdr got %h want 0000", mdr); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [15:0] d;
    load_mar(16'h0005); load_mdr(16'h5A5A); access(0, 1'b1, 1'b0, 0, lat, d);
    load_mdr(16'hDEAD);
    @(negedge clk); rw = 1'b1; mio_en = 1'b1;
    @(posedge clk); @(posedge clk); #2; rst_n = 1'b0; #1;
    checks++; if (mar !== 16'h0) begin errors++; $display("FAIL midrst_mar got %h want 0000", mar); end
    checks++; if (mdr !== 16'h0) begin errors++; $display("FAIL midrst_mdr got %h want 0000", mdr); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(negedge clk); mio_en = 1'b0; rst_n = 1'b1;
    load_mar(16'h0005);
    exp_q.push_back(16'h5A5A);
    access(0, 1'b0, 1'b1, 0, lat, d);
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL midrst_ram got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] d;
    load_mar(16'h0010); load_mdr(16'hBEEF);
    access(0, 1'b1, 1'b0, 0, lat, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_fall got %b want 0", ready); end
    load_mdr(16'h0000);
    exp_q.push_back(16'hBEEF);
    access(0, 1'b0, 1'b1, 0, lat, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL rd_data got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_abort();
    int lat; logic [15:0] d; bit seen;
    load_mar(16'h0020); load_mdr(16'h1111); access(0, 1'b1, 1'b0, 0, lat, d);
    load_mdr(16'h2222);
    @(negedge clk); rw = 1'b1; mio_en = 1'b1;
    @(posedge clk);
    @(negedge clk); mio_en = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ready) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    load_mdr(16'h0000);
    exp_q.push_back(16'h1111);
    access(0, 1'b0, 1'b1, 0, lat, d);
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL abort_ram got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_out_of_range();
    int lat; logic [15:0] d;
    load_mar(16'h0000); load_mdr(16'h0A0A); access(0, 1'b1, 1'b0, 0, lat, d);
    load_mar(16'h8000); load_mdr(16'hFFFF);
    exp_q.push_back(16'h0000);
    access(0, 1'b0, 1'b1, 0, lat, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_rd_latency got %0d want 3", lat); end
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL oor_rd_data got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    load_mdr(16'h7777);
    access(0, 1'b1, 1'b0, 0, lat, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency got %0d want 3", lat); end
    load_mar(16'h0000); load_mdr(16'h0000);
    exp_q.push_back(16'h0A0A);
    access(0, 1'b0, 1'b1, 0, lat, d);
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL oor_wr_alias got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_mar_collide_freeze();
    int lat = -1; logic [15:0] d = 'x;
    load_mdr(16'h0000);
    exp_q.push_back(16'hBEEF);
    @(negedge clk); bus = 16'h0010; ld_mar = 1'b1; rw = 1'b0; ld_mdr = 1'b1; mio_en = 1'b1;
    @(posedge clk);
    @(negedge clk); bus = 16'h0020;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready) begin lat = k; d = mdr; break; end
    end
    checks++; if (mar !== 16'h0010) begin errors++; $display("FAIL mar_frozen got %h want 0010", mar); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL collide_latency got %0d want 3", lat); end
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL collide_data got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk); ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rw_sampled_once();
    int lat; logic [15:0] d;
    load_mar(16'h0010); load_mdr(16'h4444);
    access(0, 1'b0, 1'b0, 1, lat, d);
    load_mdr(16'h0000);
    exp_q.push_back(16'hBEEF);
    access(0, 1'b0, 1'b1, 0, lat, d);
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL rw_latched got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_wait0();
    int lat; logic [15:0] d;
    load_mar(16'h0003); load_mdr(16'h1234);
    access(1, 1'b1, 1'b0, 0, lat, d);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w0_wr_latency got %0d want 1", lat); end
    load_mdr(16'h0000);
    exp_q.push_back(16'h1234);
    access(1, 1'b0, 1'b1, 0, lat, d);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w0_rd_latency got %0d want 1", lat); end
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL w0_rd_data got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

`ifdef LC3_MEM_MMIO_EN
  task automatic test_mmio();
    int lat; logic [15:0] d;
    load_mar(16'hFE00); load_mdr(16'h00A5);
    access(0, 1'b1, 1'b0, 0, lat, d);
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL mmio_led got %h want 5", led); end
    load_mdr(16'h0000);
    exp_q.push_back(16'h0005);
    access(0, 1'b0, 1'b1, 0, lat, d);
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL mmio_rd got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask
`endif

  initial begin
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; mio_en0 = 1'b0; rw = 1'b0; bus = '0;
    test_reset();
    test_reset_mid_access();
    test_write_read();
    test_abort();
    test_out_of_range();
    test_mar_collide_freeze();
    test_rw_sampled_once();
    test_wait0();
`ifdef LC3_MEM_MMIO_EN
    test_mmio();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
